systolic_tile_scheduler: RTL
============================

// Module: systolic_tile_scheduler
// PURPOSE
//  Phase sequencer for the NxN weight-stationary systolic array. It runs one or
//  more back-to-back tiles. Each tile is three phases:
//  - LOAD: row-by-row weight load.
//  - COMPUTE: row-staggered multiply enables.
//  - DRAIN: cycles for in-flight partial sums to exit.
//  The block provides a start/busy/done handshake toward the controller, plus a
//  global enable (hold) and an abort.
// PARAMETERS
//  MATRIX_SIZE  2  array dimension N; rows of PEs, one load/enable bit per row
//  PE_LATENCY   4  cycles per PE hop (L); sets stagger and compute length
//  TILE_CNT_W   8  width of tile-count input and tile index output
// PORTS
//  clk          in   1            rising-edge clock
//  reset_n      in   1            asynchronous, active-low reset
//  general_enable in 1            0 = freeze all state/counters, gate row outputs to 0
//  start        in   1            request a run; sampled only in IDLE with enable=1
//  num_tiles    in   TILE_CNT_W   tiles per run; sampled with start; 0 treated as 1
//  abort        in   1            synchronous abort; return to IDLE, no done
//  load_weight  out  MATRIX_SIZE  one-hot row weight-load strobe
//  enable_mult  out  MATRIX_SIZE  per-row multiply enable
//  busy         out  1            high in LOAD/COMPUTE/DRAIN/DONE
//  done         out  1            high in DONE state (one enabled cycle)
//  tile_idx     out  TILE_CNT_W   index of the tile in progress, 0-based
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE; all counters=0; every output = 0.
//  States: IDLE -> LOAD -> COMPUTE -> DRAIN -> (LOAD | DONE) -> IDLE.
//  Transitions are taken only on edges with general_enable=1.
//  - IDLE: on start=1, latch max(num_tiles,1), set tile_idx=0, and go to LOAD.
//    The first load_weight cycle is the cycle after start is sampled.
//  - LOAD: lasts N cycles. In load cycle k (0..N-1), load_weight = 1<<k.
//    Then go to COMPUTE.
//  - COMPUTE: lasts C=(2N-1)*L cycles, using cycle count c=0..C-1.
//    enable_mult[r]=1 iff r*L <= c < r*L + N*L.
//    Row 0 starts first; row N-1 ends at c=C-1. Then go to DRAIN.
//  - DRAIN: lasts D=N+L cycles with all row outputs 0.
//    If tile_idx+1 < latched count: tile_idx++ and go to LOAD.
//    Otherwise go to DONE.
//  - DONE: done=1 and busy=1 for one enabled cycle, then IDLE.
//    tile_idx is held in DONE and cleared on the move to IDLE.
//  - Cycles per tile: N + C + D. No overlap between tiles.
//  - Row outputs are combinational decodes of registered state and counter, ANDed
//    with general_enable. busy, done and tile_idx are not gated.
//  general_enable=0: state, counters and tile_idx hold; load_weight=enable_mult=0.
//  A run resumes exactly where it stopped when enable returns.
//  start outside IDLE is ignored; num_tiles changes after sampling have no effect.
//  abort=1 (enable=1) in any non-IDLE state: go to IDLE next edge, clear counters.
//  No done pulse is produced. abort has priority over start in the same cycle.
//  With enable=0, abort is ignored.
//  Counter widths: $clog2 of the maximum phase length plus 1. No counter wraps.
//  Each phase counter clears on phase exit.
//  Reset asserted mid-run: immediate IDLE, outputs 0. After release, wait for start.
// TESTING (N=2, L=4: LOAD 2, COMPUTE 12, DRAIN 6 cycles)
//  1. Single tile: reset, then start=1, num_tiles=1 for 1 cycle.
//     - load_weight=01 then 10.
//     - enable_mult[0] high for compute c=0..7 and [1] high for c=4..11.
//     - 6 idle drain cycles, then done=1 for exactly 1 cycle.
//     - done falls 21 cycles after start; busy is high for 21 cycles.
//  2. Multi-tile: num_tiles=3.
//     - Three identical 20-cycle tile sequences; tile_idx=0,1,2.
//     - A single done pulse after the third drain. busy is continuous.
//  3. Hold: drop general_enable for 5 cycles at compute c=5.
//     - Row outputs are 0 during the hold.
//     - On resume, c continues at 5; total run length grows by exactly 5.
//  4. Abort: assert abort at compute c=3 of tile 1 (num_tiles=2).
//     - Next cycle: IDLE, busy=0, all outputs 0, no done.
//     - A later start runs cleanly from tile 0.
//  5. Corner inputs: num_tiles=0 runs exactly one tile.
//     - start during COMPUTE is ignored.
//     - abort and start together in IDLE: stays IDLE.
//  6. Async reset_n pulse mid-LOAD, between edges: outputs are 0 immediately.
//     - The block stays idle until the next start.

Source files
------------

// File: rtl/systolic_tile_scheduler_if.sv
// Handshake and row-strobe bundle between the array controller and the tile scheduler.
interface systolic_tile_scheduler_if #(
    parameter int MATRIX_SIZE = 2,
    parameter int TILE_CNT_W  = 8
);
    logic                   general_enable;
    logic                   start;
    logic [TILE_CNT_W-1:0]  num_tiles;
    logic                   abort;
    logic [MATRIX_SIZE-1:0] load_weight;
    logic [MATRIX_SIZE-1:0] enable_mult;
    logic                   busy;
    logic                   done;
    logic [TILE_CNT_W-1:0]  tile_idx;

    modport master (
        output general_enable, start, num_tiles, abort,
        input  load_weight, enable_mult, busy, done, tile_idx
    );

    modport slave (
        input  general_enable, start, num_tiles, abort,
        output load_weight, enable_mult, busy, done, tile_idx
    );
endinterface

// File: rtl/systolic_tile_scheduler.sv
// Phase sequencer for an NxN weight-stationary systolic array: per tile it runs
// LOAD -> COMPUTE -> DRAIN, repeating for the latched tile count, then pulses done.
module systolic_tile_scheduler #(
    parameter int MATRIX_SIZE = 2,
    parameter int PE_LATENCY  = 4,
    parameter int TILE_CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    systolic_tile_scheduler_if.slave    bus
);
    localparam int N       = MATRIX_SIZE;
    localparam int L       = PE_LATENCY;
    localparam int C_LEN   = (2 * N - 1) * L;
    localparam int D_LEN   = N + L;
    localparam int MAX_LEN = (C_LEN > D_LEN) ? ((C_LEN > N) ? C_LEN : N)
                                             : ((D_LEN > N) ? D_LEN : N);
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [TILE_CNT_W-1:0]  r_tile, w_tile_nxt;
    logic [TILE_CNT_W-1:0]  r_tiles, w_tiles_nxt;
    logic                   w_last_tile;
    logic [MATRIX_SIZE-1:0] w_load_weight;
    logic [MATRIX_SIZE-1:0] w_enable_mult;

    assign w_last_tile = ({1'b0, r_tile} + (TILE_CNT_W+1)'(1)) >= {1'b0, r_tiles};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tile  <= '0;
            r_tiles <= '0;
        end else if (bus.general_enable) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tile  <= w_tile_nxt;
            r_tiles <= w_tiles_nxt;
        end
    end

    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tile_nxt  = r_tile;
        w_tiles_nxt = r_tiles;
        if (bus.abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_tile_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        w_state_nxt = S_LOAD;
                        w_cnt_nxt   = '0;
                        w_tile_nxt  = '0;
                        w_tiles_nxt = (bus.num_tiles == '0) ? TILE_CNT_W'(1) : bus.num_tiles;
                    end
                end
                S_LOAD: begin
                    if (r_cnt == CNT_W'(N - 1)) begin
                        w_state_nxt = S_COMPUTE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_COMPUTE: begin
                    if (r_cnt == CNT_W'(C_LEN - 1)) begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == CNT_W'(D_LEN - 1)) begin
                        w_cnt_nxt = '0;
                        if (w_last_tile) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_LOAD;
                            w_tile_nxt  = r_tile + TILE_CNT_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                    w_tile_nxt  = '0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_tile_nxt  = '0;
                end
            endcase
        end
    end

    // Row r multiplies for N*L cycles starting L cycles after row r-1.
    always_comb begin
        w_load_weight = '0;
        w_enable_mult = '0;
        if (bus.general_enable && r_state == S_LOAD) begin
            w_load_weight = MATRIX_SIZE'(1) << r_cnt;
        end
        if (bus.general_enable && r_state == S_COMPUTE) begin
            for (int r = 0; r < N; r++) begin
                w_enable_mult[r] = (r_cnt >= CNT_W'(r * L)) && (r_cnt < CNT_W'(r * L + N * L));
            end
        end
    end

    assign bus.load_weight = w_load_weight;
    assign bus.enable_mult = w_enable_mult;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.tile_idx    = r_tile;
endmodule
